// File: rtl/cpu_pkg.sv
// Shared constants for the Phase 2 CPU: opcodes, ALU selects, step encoding
// and the bundle of datapath control lines driven by the sequencer.
package cpu_pkg;
  localparam int OPCODE_W = 5;
  localparam int CTRL_W   = 5;
  localparam int STEP_W   = 3;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [CTRL_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [CTRL_W-1:0] ALU_AND = 5'b00010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 5'b00011;

  localparam logic [STEP_W-1:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_BR, CLS_NOP, CLS_HALT, CLS_ILL
  } iclass_e;

  typedef enum logic [1:0] {MODE_RESET, MODE_RUN, MODE_HALT} mode_e;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, c_out, ba_out, r_out;
    logic pc_in, mdr_in, mar_in, ir_in, y_in, zlo_in, con_in;
    logic g_ra, g_rb, g_rc, r_in;
    logic inc_pc, read, write;
  } ctrl_t;

  // Final execute step of each instruction class; the step after it is T0.
  function automatic logic [STEP_W-1:0] last_step(iclass_e c);
    case (c)
      CLS_ALU, CLS_IMM, CLS_LDI: return T5;
      CLS_BR:                    return T6;
      CLS_LD, CLS_ST:            return T7;
      default:                   return T3;
    endcase
  endfunction
endpackage

// File: rtl/op_decode.sv
// Combinational map from the IR opcode field to an instruction class and ALU select.
module op_decode
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output iclass_e             iclass_o,
  output logic [CTRL_W-1:0]   alu_sel_o
);
  always_comb begin
    iclass_o  = CLS_ILL;
    alu_sel_o = ALU_ADD;
    case (opcode_i)
      OP_LD:   iclass_o = CLS_LD;
      OP_LDI:  iclass_o = CLS_LDI;
      OP_ST:   iclass_o = CLS_ST;
      OP_ADD:  iclass_o = CLS_ALU;
      OP_SUB:  begin iclass_o = CLS_ALU; alu_sel_o = ALU_SUB; end
      OP_AND:  begin iclass_o = CLS_ALU; alu_sel_o = ALU_AND; end
      OP_OR:   begin iclass_o = CLS_ALU; alu_sel_o = ALU_OR;  end
      OP_ADDI: iclass_o = CLS_IMM;
      OP_ANDI: begin iclass_o = CLS_IMM; alu_sel_o = ALU_AND; end
      OP_ORI:  begin iclass_o = CLS_IMM; alu_sel_o = ALU_OR;  end
      OP_BR:   iclass_o = CLS_BR;
      OP_NOP:  iclass_o = CLS_NOP;
      OP_HALT: iclass_o = CLS_HALT;
      default: iclass_o = CLS_ILL;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetch T0-T2, per-class execute T3-T7, halted until Clear.
// Outputs are a Moore decode of step/mode/IR, except PC_In which follows ConFF_Out in br T6.
module control_unit
  import cpu_pkg::*;
(
  input  logic              Clock,
  input  logic              Clear,
  input  logic [31:0]       IR,
  input  logic              ConFF_Out,
  output logic              PC_Out,
  output logic              MDR_Out,
  output logic              ZLO_Out,
  output logic              C_Out,
  output logic              BA_Out,
  output logic              PC_In,
  output logic              MDR_In,
  output logic              MAR_In,
  output logic              IR_In,
  output logic              Y_In,
  output logic              ZLO_In,
  output logic              Con_In,
  output logic              G_RA,
  output logic              G_RB,
  output logic              G_RC,
  output logic              R_In,
  output logic              R_Out,
  output logic              IncPC,
  output logic              Read,
  output logic              Write,
  output logic [CTRL_W-1:0] CONTROL,
  output logic              Run,
  output logic              Illegal,
  output logic [STEP_W-1:0] Step
);
  mode_e              mode_q, mode_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               illegal_q, illegal_d;
  iclass_e            iclass;
  logic [CTRL_W-1:0]  alu_sel;
  ctrl_t              ctrl;
  logic               unused_ir;

  assign unused_ir = ^IR[31-OPCODE_W:0];

  op_decode u_op_decode (
    .opcode_i  (IR[31 -: OPCODE_W]),
    .iclass_o  (iclass),
    .alu_sel_o (alu_sel)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      mode_q    <= MODE_RESET;
      step_q    <= T0;
      illegal_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    step_d    = step_q;
    illegal_d = illegal_q;
    ctrl      = '0;
    CONTROL   = ALU_ADD;
    case (mode_q)
      MODE_RESET: begin
        mode_d = MODE_RUN;
        step_d = T0;
      end
      MODE_RUN: begin
        // Returning on ">= last" also covers IR changing under a long sequence.
        if (step_q < T3) begin
          step_d = step_q + 3'd1;
        end else if (step_q >= last_step(iclass) || step_q == T7) begin
          step_d = T0;
          if (iclass == CLS_HALT || iclass == CLS_ILL) begin
            mode_d    = MODE_HALT;
            illegal_d = illegal_q | (iclass == CLS_ILL);
          end
        end else begin
          step_d = step_q + 3'd1;
        end

        case (step_q)
          T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
          T1: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
          T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
          T3: case (iclass)
            CLS_ALU, CLS_IMM: begin ctrl.g_rb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            CLS_LDI, CLS_LD, CLS_ST: begin ctrl.g_rb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
            CLS_BR: begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
            default: ;
          endcase
          T4: case (iclass)
            CLS_ALU: begin ctrl.g_rc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlo_in = 1'b1; CONTROL = alu_sel; end
            CLS_IMM: begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; CONTROL = alu_sel; end
            CLS_LDI, CLS_LD, CLS_ST: begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; end
            CLS_BR: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
            default: ;
          endcase
          T5: case (iclass)
            CLS_ALU, CLS_IMM, CLS_LDI: begin ctrl.zlo_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_LD, CLS_ST: begin ctrl.zlo_out = 1'b1; ctrl.mar_in = 1'b1; end
            CLS_BR: begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; end
            default: ;
          endcase
          T6: case (iclass)
            CLS_LD: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
            CLS_ST: begin ctrl.g_ra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
            CLS_BR: begin ctrl.zlo_out = 1'b1; ctrl.pc_in = ConFF_Out; end
            default: ;
          endcase
          T7: case (iclass)
            CLS_LD: begin ctrl.mdr_out = 1'b1; ctrl.g_ra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_ST: ctrl.write = 1'b1;
            default: ;
          endcase
          default: ;
        endcase
      end
      default: begin
        mode_d = MODE_HALT;
        step_d = T0;
      end
    endcase
  end

  assign {PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out} =
         {ctrl.pc_out, ctrl.mdr_out, ctrl.zlo_out, ctrl.c_out, ctrl.ba_out, ctrl.r_out};
  assign {PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, Con_In} =
         {ctrl.pc_in, ctrl.mdr_in, ctrl.mar_in, ctrl.ir_in, ctrl.y_in, ctrl.zlo_in, ctrl.con_in};
  assign {G_RA, G_RB, G_RC, R_In} = {ctrl.g_ra, ctrl.g_rb, ctrl.g_rc, ctrl.r_in};
  assign {IncPC, Read, Write} = {ctrl.inc_pc, ctrl.read, ctrl.write};
  assign Run     = (mode_q == MODE_RUN);
  assign Illegal = illegal_q;
  assign Step    = step_q;
endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: stimulus pushes the expected
// per-cycle control word, a negedge monitor pops and compares.
module tb_control_unit;
  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        ConFF_Out;
  logic PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, PC_In, MDR_In, MAR_In, IR_In;
  logic Y_In, ZLO_In, Con_In, G_RA, G_RB, G_RC, R_In, R_Out, IncPC, Read, Write;
  logic [4:0] CONTROL;
  logic       Run, Illegal;
  logic [2:0] Step;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .ConFF_Out(ConFF_Out),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .C_Out(C_Out), .BA_Out(BA_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZLO_In(ZLO_In), .Con_In(Con_In), .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC),
    .R_In(R_In), .R_Out(R_Out), .IncPC(IncPC), .Read(Read), .Write(Write),
    .CONTROL(CONTROL), .Run(Run), .Illegal(Illegal), .Step(Step)
  );

  always #5 Clock = ~Clock;

  localparam logic [19:0] M_PC_OUT = 20'h80000, M_MDR_OUT = 20'h40000, M_ZLO_OUT = 20'h20000;
  localparam logic [19:0] M_C_OUT  = 20'h10000, M_BA_OUT  = 20'h08000, M_R_OUT   = 20'h04000;
  localparam logic [19:0] M_PC_IN  = 20'h02000, M_MDR_IN  = 20'h01000, M_MAR_IN  = 20'h00800;
  localparam logic [19:0] M_IR_IN  = 20'h00400, M_Y_IN    = 20'h00200, M_ZLO_IN  = 20'h00100;
  localparam logic [19:0] M_CON_IN = 20'h00080, M_G_RA    = 20'h00040, M_G_RB    = 20'h00020;
  localparam logic [19:0] M_G_RC   = 20'h00010, M_R_IN    = 20'h00008, M_INC_PC  = 20'h00004;
  localparam logic [19:0] M_READ   = 20'h00002, M_WRITE   = 20'h00001;
  localparam logic [19:0] M_BUS = M_PC_OUT | M_MDR_OUT | M_ZLO_OUT | M_C_OUT | M_BA_OUT | M_R_OUT;

  typedef struct packed {
    logic [19:0] ctrl;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
    logic [2:0]  step;
  } obs_t;

  logic [19:0] ctrl_obs;
  assign ctrl_obs = {PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out, PC_In, MDR_In, MAR_In,
                     IR_In, Y_In, ZLO_In, Con_In, G_RA, G_RB, G_RC, R_In, IncPC, Read, Write};

  obs_t        sb[$];
  string       tag_q[$];
  logic [19:0] plan_c[$];
  logic [4:0]  plan_a[$];
  int          checks = 0;
  int          failures = 0;
  bit          ill_m = 1'b0;
  logic [4:0]  legal_ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd18, 5'd26};

  function automatic obs_t mk(logic [19:0] c, logic [4:0] a, logic run, logic ill, logic [2:0] st);
    obs_t e;
    e.ctrl = c; e.alu = a; e.run = run; e.ill = ill; e.step = st;
    return e;
  endfunction

  function automatic bit is_legal(logic [4:0] op);
    for (int i = 0; i < 12; i++) if (legal_ops[i] == op) return 1'b1;
    return op == 5'd27;
  endfunction

  function automatic logic [4:0] alu_of(logic [4:0] op);
    case (op)
      5'd4:        return 5'd1;
      5'd5, 5'd13: return 5'd2;
      5'd6, 5'd14: return 5'd3;
      default:     return 5'd0;
    endcase
  endfunction

  task automatic add_step(input logic [19:0] c, input logic [4:0] a);
    plan_c.push_back(c);
    plan_a.push_back(a);
  endtask

  // Reference model: the instruction as an ordered list of control words.
  task automatic build_plan(input logic [4:0] op);
    plan_c.delete();
    plan_a.delete();
    add_step(M_PC_OUT | M_MAR_IN | M_INC_PC, 5'd0);
    add_step(M_READ | M_MDR_IN, 5'd0);
    add_step(M_MDR_OUT | M_IR_IN, 5'd0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        add_step(M_G_RB | M_R_OUT | M_Y_IN, 5'd0);
        add_step(M_G_RC | M_R_OUT | M_ZLO_IN, alu_of(op));
        add_step(M_ZLO_OUT | M_G_RA | M_R_IN, 5'd0);
      end
      5'd12, 5'd13, 5'd14: begin
        add_step(M_G_RB | M_R_OUT | M_Y_IN, 5'd0);
        add_step(M_C_OUT | M_ZLO_IN, alu_of(op));
        add_step(M_ZLO_OUT | M_G_RA | M_R_IN, 5'd0);
      end
      5'd0, 5'd1, 5'd2: begin
        add_step(M_G_RB | M_BA_OUT | M_Y_IN, 5'd0);
        add_step(M_C_OUT | M_ZLO_IN, 5'd0);
        if (op == 5'd1) add_step(M_ZLO_OUT | M_G_RA | M_R_IN, 5'd0);
        else            add_step(M_ZLO_OUT | M_MAR_IN, 5'd0);
        if (op == 5'd0) begin
          add_step(M_READ | M_MDR_IN, 5'd0);
          add_step(M_MDR_OUT | M_G_RA | M_R_IN, 5'd0);
        end
        if (op == 5'd2) begin
          add_step(M_G_RA | M_R_OUT | M_MDR_IN, 5'd0);
          add_step(M_WRITE, 5'd0);
        end
      end
      5'd18: begin
        add_step(M_G_RA | M_R_OUT | M_CON_IN, 5'd0);
        add_step(M_PC_OUT | M_Y_IN, 5'd0);
        add_step(M_C_OUT | M_ZLO_IN, 5'd0);
        add_step(M_ZLO_OUT, 5'd0);
      end
      default: add_step(20'h0, 5'd0);
    endcase
  endtask

  task automatic push(input obs_t e, input string tag);
    sb.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    Clear = 1'b1;
    ill_m = 1'b0;
    for (int i = 0; i < n; i++) push(mk(20'h0, 5'd0, 1'b0, 1'b0, 3'd0), "reset");
    Clear = 1'b0;
    push(mk(20'h0, 5'd0, 1'b0, 1'b0, 3'd0), "release");
  endtask

  task automatic halted_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      IR = $urandom();
      ConFF_Out = 1'($urandom_range(0, 1));
      push(mk(20'h0, 5'd0, 1'b0, ill_m, 3'd0), "halted");
    end
  endtask

  // conff_mode: 0/1 hold ConFF_Out fixed, 2 randomizes it every cycle.
  task automatic run_instr(input logic [31:0] ir, input int conff_mode, input int abort_at);
    logic [4:0]  op;
    logic [19:0] c;
    op = ir[31:27];
    IR = ir;
    build_plan(op);
    for (int k = 0; k < plan_c.size(); k++) begin
      ConFF_Out = (conff_mode == 2) ? 1'($urandom_range(0, 1)) : (conff_mode == 1);
      if (k == abort_at) begin
        Clear = 1'b1;
        ill_m = 1'b0;
        push(mk(20'h0, 5'd0, 1'b0, 1'b0, 3'd0), $sformatf("abort ir=%08h T%0d", ir, k));
        Clear = 1'b0;
        push(mk(20'h0, 5'd0, 1'b0, 1'b0, 3'd0), $sformatf("abort-release ir=%08h", ir));
        $display("TXN ir=%08h aborted at T%0d", ir, k);
        return;
      end
      c = plan_c[k];
      if (op == 5'd18 && k == 6 && ConFF_Out) c = c | M_PC_IN;
      push(mk(c, plan_a[k], 1'b1, ill_m, 3'(k)), $sformatf("ir=%08h T%0d", ir, k));
    end
    if (!is_legal(op)) ill_m = 1'b1;
    $display("TXN ir=%08h op=%0d cycles=%0d illegal=%0b", ir, op, plan_c.size(), ill_m);
  endtask

  initial begin : monitor
    obs_t  e, o;
    string t;
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        t = tag_q.pop_front();
        o = mk(ctrl_obs, CONTROL, Run, Illegal, Step);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL %s: got ctrl=%05h alu=%0d run=%0b ill=%0b step=%0d, expected ctrl=%05h alu=%0d run=%0b ill=%0b step=%0d",
                   t, o.ctrl, o.alu, o.run, o.ill, o.step, e.ctrl, e.alu, e.run, e.ill, e.step);
        end
        checks++;
        if ((Read && Write) || !$onehot0(ctrl_obs & M_BUS)) begin
          failures++;
          $display("FAIL exclusive %s: got ctrl=%05h, expected one bus driver at most and no Read with Write", t, ctrl_obs);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] r;
    logic [4:0]  op;
    int          ab;
    Clear = 1'b1;
    IR = 32'h0;
    ConFF_Out = 1'b0;
    @(posedge Clock);
    #1;
    do_reset(2);
    run_instr(32'h18918000, 2, -1);
    run_instr(32'h18918000, 2, 4);
    run_instr(32'h18918000, 2, -1);
    run_instr(32'h91000023, 1, -1);
    run_instr(32'h91000023, 0, -1);
    run_instr(32'h00900055, 2, -1);
    run_instr(32'h10900055, 2, -1);
    run_instr(32'h10900055, 2, 7);
    run_instr(32'hD0000000, 2, -1);
    for (int n = 0; n < 60; n++) begin
      r  = $urandom();
      op = legal_ops[$urandom_range(0, 11)];
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr({op, r[26:0]}, 2, ab);
    end
    run_instr(32'hD8000000, 2, -1);
    halted_cycles(20);
    do_reset(1);
    run_instr(32'hD0000000, 2, -1);
    run_instr(32'hF8000000, 2, -1);
    halted_cycles(5);
    do_reset(1);
    run_instr(32'h68918000, 2, -1);
    @(negedge Clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
